// File: rtl/serial_calc_unit_if.sv
// serial_calc_unit_if
//  Handshake and data bundle between the calculator control logic (master)
//  and the serial arithmetic unit (slave).
//  master drives: start, op, a, b
//  slave drives : busy, done, result, carry, overflow, err
interface serial_calc_unit_if #(
    parameter int WIDTH = 8
) ();
    logic                 start;
    logic [1:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;
    logic                 carry;
    logic                 overflow;
    logic                 err;

    modport master (
        output start, op, a, b,
        input  busy, done, result, carry, overflow, err
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, carry, overflow, err
    );
endinterface

// File: rtl/serial_calc_unit.sv
// serial_calc_unit
//  Multi-cycle WIDTH-bit arithmetic unit. ADD/SUB run one full-adder slice
//  bit-serially (LSB first), MUL runs a shift-add loop; both take WIDTH steps
//  after the accepting edge. The reserved opcode finishes after one step with err.
//  Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - slave side of serial_calc_unit_if (start/op/a/b in;
//          busy/done/result/carry/overflow/err out, all registered)
module serial_calc_unit #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_calc_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int W2 = 2 * WIDTH;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_next_s;

    logic [1:0]        op_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [CW-1:0]     cnt_r;
    logic              c_r;
    logic [WIDTH-1:0]  sum_r;
    logic [W2-1:0]     acc_r;

    logic              busy_r;
    logic              done_r;
    logic [W2-1:0]     result_r;
    logic              carry_r;
    logic              overflow_r;
    logic              err_r;

    logic [IW-1:0]     idx_s;
    logic              a_bit_s;
    logic              b_bit_s;
    logic              sum_bit_s;
    logic              c_next_s;
    logic [WIDTH-1:0]  sum_full_s;
    logic [W2-1:0]     acc_next_s;
    logic              last_s;
    logic              accept_s;
    logic              finish_s;

    // One bit-serial adder slice and one shift-add step for the current counter value
    always_comb begin
        idx_s      = cnt_r[IW-1:0];
        a_bit_s    = a_r[idx_s];
        // SUB adds the inverted subtrahend; the +1 comes from c0 = 1 at accept
        b_bit_s    = (op_r[0] == 1'b1) ? ~b_r[idx_s] : b_r[idx_s];
        sum_bit_s  = a_bit_s ^ b_bit_s ^ c_r;
        c_next_s   = (a_bit_s & b_bit_s) | (a_bit_s & c_r) | (b_bit_s & c_r);
        sum_full_s = sum_r;
        sum_full_s[idx_s] = sum_bit_s;
        if (b_r[idx_s] == 1'b1) begin
            acc_next_s = acc_r + ({{WIDTH{1'b0}}, a_r} << idx_s);
        end else begin
            acc_next_s = acc_r;
        end
        last_s = (cnt_r == LAST_STEP) || (op_r == 2'b11);
    end

    // Next-state and control strobes
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.start == 1'b1) begin
                    state_next_s = S_RUN;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s == 1'b1) begin
                    state_next_s = S_IDLE;
                    finish_s     = 1'b1;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand latch, serial datapath and registered results/flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r       <= 2'b00;
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            cnt_r      <= {CW{1'b0}};
            c_r        <= 1'b0;
            sum_r      <= {WIDTH{1'b0}};
            acc_r      <= {W2{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= {W2{1'b0}};
            carry_r    <= 1'b0;
            overflow_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept_s) begin
                op_r   <= bus.op;
                a_r    <= bus.a;
                b_r    <= bus.b;
                cnt_r  <= {CW{1'b0}};
                c_r    <= (bus.op == 2'b01);
                sum_r  <= {WIDTH{1'b0}};
                acc_r  <= {W2{1'b0}};
                busy_r <= 1'b1;
            end else if (state_r == S_RUN) begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                c_r   <= c_next_s;
                sum_r <= sum_full_s;
                acc_r <= acc_next_s;
                if (finish_s) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    // On the final step the current slice bits are the MSBs
                    case (op_r)
                        2'b00, 2'b01: begin
                            result_r   <= {{WIDTH{1'b0}}, sum_full_s};
                            carry_r    <= c_next_s;
                            overflow_r <= (a_bit_s == b_bit_s) && (sum_bit_s != a_bit_s);
                            err_r      <= 1'b0;
                        end
                        2'b10: begin
                            result_r   <= acc_next_s;
                            carry_r    <= 1'b0;
                            overflow_r <= |acc_next_s[W2-1:WIDTH];
                            err_r      <= 1'b0;
                        end
                        default: begin
                            result_r   <= {W2{1'b0}};
                            carry_r    <= 1'b0;
                            overflow_r <= 1'b0;
                            err_r      <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.result   = result_r;
    assign bus.carry    = carry_r;
    assign bus.overflow = overflow_r;
    assign bus.err      = err_r;
endmodule

// File: tb/tb_serial_calc_unit.sv
// tb_serial_calc_unit
//  Scoreboard bench for serial_calc_unit (WIDTH=8): expected results are
//  computed with plain arithmetic when an operation is started and compared
//  when DONE is seen.
module tb_serial_calc_unit;
    localparam int W = 8;

    typedef struct packed {
        logic [2*W-1:0] result;
        logic           carry;
        logic           ovf;
        logic           err;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t sb_q[$];

    serial_calc_unit_if #(.WIDTH(W)) bus ();

    serial_calc_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expectation
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t           e;
        logic [W:0]     s;
        logic [2*W-1:0] p;
        e = '{result: 16'h0000, carry: 1'b0, ovf: 1'b0, err: 1'b0};
        case (op)
            2'b00: begin
                s        = {1'b0, a} + {1'b0, b};
                e.result = {8'h00, s[W-1:0]};
                e.carry  = s[W];
                e.ovf    = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            end
            2'b01: begin
                s        = {1'b0, a} - {1'b0, b};
                e.result = {8'h00, s[W-1:0]};
                e.carry  = (a >= b);
                e.ovf    = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
            end
            2'b10: begin
                p        = {8'h00, a} * {8'h00, b};
                e.result = p;
                e.ovf    = (p > 16'h00FF);
            end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // Pulse start for one cycle; returns at the falling edge after the accepting edge
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        sb_q.push_back(model(op, a, b));
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    endtask

    // Wait (bounded) for done, check latency and pop/compare the scoreboard
    task automatic wait_done(input string tag, input int lat);
        int   n;
        exp_t e;
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.done !== 1'b1) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_lat"},    n, lat);
            chk({tag, "_busy"},   {31'd0, bus.busy}, 32'd0);
            chk({tag, "_result"}, {16'd0, bus.result}, {16'd0, e.result});
            chk({tag, "_carry"},  {31'd0, bus.carry}, {31'd0, e.carry});
            chk({tag, "_ovf"},    {31'd0, bus.overflow}, {31'd0, e.ovf});
            chk({tag, "_err"},    {31'd0, bus.err}, {31'd0, e.err});
            @(negedge clk);
            chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start_op(op, a, b);
        wait_done(tag, (op == 2'b11) ? 1 : W);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"},
            {10'd0, bus.busy, bus.done, bus.result, bus.carry, bus.overflow, bus.err, 1'b0},
            32'd0);
    endtask

    initial begin
        int  seen_done;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Directed cases
        run_op("add_ff_01", 2'b00, 8'hFF, 8'h01);
        run_op("sub_80_01", 2'b01, 8'h80, 8'h01);
        run_op("sub_00_01", 2'b01, 8'h00, 8'h01);
        run_op("mul_ff_ff", 2'b10, 8'hFF, 8'hFF);
        run_op("mul_0f_03", 2'b10, 8'h0F, 8'h03);

        // START re-pulse while busy is ignored
        start_op(2'b00, 8'h7F, 8'h01);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h00;
        bus.b     = 8'h55;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("add_ignore", W - 3);

        // Reset mid-operation aborts with no done
        start_op(2'b10, 8'h12, 8'h34);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midreset");
        rst = 1'b0;
        void'(sb_q.pop_front());
        seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen_done = 1;
        end
        chk("no_done_after_abort", seen_done, 0);
        run_op("add_01_01", 2'b00, 8'h01, 8'h01);

        // Reserved op with START held through DONE
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        sb_q.push_back(model(2'b11, 8'hAA, 8'h55));
        @(negedge clk);
        chk("rsv_busy", {31'd0, bus.busy}, 32'd1);
        bus.op = 2'b00;
        bus.a  = 8'h03;
        bus.b  = 8'h04;
        @(negedge clk);
        begin
            exp_t e;
            e = sb_q.pop_front();
            chk("rsv_done",   {31'd0, bus.done}, 32'd1);
            chk("rsv_err",    {31'd0, bus.err}, {31'd0, e.err});
            chk("rsv_result", {16'd0, bus.result}, {16'd0, e.result});
            chk("rsv_nobusy", {31'd0, bus.busy}, 32'd0);
        end
        sb_q.push_back(model(2'b00, 8'h03, 8'h04));
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
        wait_done("b2b_add", W);

        // A few random operations
        for (int i = 0; i < 8; i++) begin
            run_op("rand", 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
